// File: rtl/g76_memory_pkg.sv
`default_nettype none
// g76_memory_pkg: shared SRAM geometry, types and arbiter enums.
// Revision: 1.0 initial release
package g76_memory_pkg;

   localparam int ADDRESS_WIDTH = 17;
   localparam int DATA_WIDTH    = 8;

   typedef logic [ADDRESS_WIDTH-1:0] memory_address_t;
   typedef logic [DATA_WIDTH-1:0]    memory_data_t;

   typedef enum logic [2:0] {
      IDLE        = 3'd0,
      READ        = 3'd1,
      WRITE_SETUP = 3'd2,
      WRITE_PULSE = 3'd3,
      DONE        = 3'd4
   } arbiter_state_t;

   typedef enum logic [1:0] {
      VIDEO     = 2'd0,
      MCU_WRITE = 2'd1,
      MCU_READ  = 2'd2
   } requester_t;

endpackage
`default_nettype wire

// File: rtl/sram_arbiter.sv
`default_nettype none
// sram_arbiter: video-priority arbiter and pin sequencer for one async SRAM.
// Optional SRAM_ARB_STATS_EN adds the mcuStallCycles counter. Revision: 1.0
module sram_arbiter #(
   parameter int ACCESS_CYCLES = 2,
   parameter int ADDRESS_WIDTH = g76_memory_pkg::ADDRESS_WIDTH,
   parameter int DATA_WIDTH    = g76_memory_pkg::DATA_WIDTH
) (
   input  logic                     clock,
   input  logic                     reset,
   input  logic                     videoReadRequest,
   input  logic [ADDRESS_WIDTH-1:0] videoAddress,
   output logic [DATA_WIDTH-1:0]    videoReadData,
   output logic                     videoReadComplete,
   input  logic                     mcuWriteRequest,
   input  logic                     mcuReadRequest,
   input  logic [ADDRESS_WIDTH-1:0] mcuAddress,
   input  logic [DATA_WIDTH-1:0]    mcuWriteData,
   output logic                     mcuWriteComplete,
   output logic [DATA_WIDTH-1:0]    mcuReadData,
   output logic                     mcuReadComplete,
   output logic [ADDRESS_WIDTH-1:0] sramAddress,
   output logic [DATA_WIDTH-1:0]    sramDataOut,
   input  logic [DATA_WIDTH-1:0]    sramDataIn,
   output logic                     sramDataDrive,
   output logic                     sramChipEnable_n,
   output logic                     sramOutputEnable_n,
   output logic                     sramWriteEnable_n
`ifdef SRAM_ARB_STATS_EN
   ,
   output logic [15:0]              mcuStallCycles
`endif
);

   import g76_memory_pkg::*;

   localparam logic [3:0] c_LAST_COUNT = 4'(ACCESS_CYCLES - 1);

   generate
      if (ACCESS_CYCLES < 1 || ACCESS_CYCLES > 15) begin : g_bad_access_cycles
         $error("sram_arbiter: ACCESS_CYCLES must be within 1..15");
      end
   endgenerate

   arbiter_state_t r_state;
   requester_t     r_requester;
   logic [3:0]     r_count;

   // Complete pulses are raised on entry to DONE, so a requester that drops
   // its request on the pulse is already low when IDLE samples again.
   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         r_state            <= IDLE;
         r_requester        <= VIDEO;
         r_count            <= '0;
         sramAddress        <= '0;
         sramDataOut        <= '0;
         sramDataDrive      <= 1'b0;
         sramChipEnable_n   <= 1'b1;
         sramOutputEnable_n <= 1'b1;
         sramWriteEnable_n  <= 1'b1;
         videoReadData      <= '0;
         mcuReadData        <= '0;
         videoReadComplete  <= 1'b0;
         mcuWriteComplete   <= 1'b0;
         mcuReadComplete    <= 1'b0;
      end else begin
         videoReadComplete <= 1'b0;
         mcuWriteComplete  <= 1'b0;
         mcuReadComplete   <= 1'b0;
         case (r_state)
            IDLE: begin
               r_count <= '0;
               if (videoReadRequest) begin
                  r_requester        <= VIDEO;
                  sramAddress        <= videoAddress;
                  sramChipEnable_n   <= 1'b0;
                  sramOutputEnable_n <= 1'b0;
                  r_state            <= READ;
               end else if (mcuWriteRequest) begin
                  r_requester      <= MCU_WRITE;
                  sramAddress      <= mcuAddress;
                  sramDataOut      <= mcuWriteData;
                  sramDataDrive    <= 1'b1;
                  sramChipEnable_n <= 1'b0;
                  r_state          <= WRITE_SETUP;
               end else if (mcuReadRequest) begin
                  r_requester        <= MCU_READ;
                  sramAddress        <= mcuAddress;
                  sramChipEnable_n   <= 1'b0;
                  sramOutputEnable_n <= 1'b0;
                  r_state            <= READ;
               end
            end
            READ: begin
               if (r_count == c_LAST_COUNT) begin
                  if (r_requester == VIDEO) begin
                     videoReadData     <= sramDataIn;
                     videoReadComplete <= 1'b1;
                  end else begin
                     mcuReadData     <= sramDataIn;
                     mcuReadComplete <= 1'b1;
                  end
                  sramOutputEnable_n <= 1'b1;
                  r_count            <= '0;
                  r_state            <= DONE;
               end else begin
                  r_count <= r_count + 4'd1;
               end
            end
            WRITE_SETUP: begin
               sramWriteEnable_n <= 1'b0;
               r_state           <= WRITE_PULSE;
            end
            WRITE_PULSE: begin
               if (r_count == c_LAST_COUNT) begin
                  sramWriteEnable_n <= 1'b1;
                  mcuWriteComplete  <= 1'b1;
                  r_count           <= '0;
                  r_state           <= DONE;
               end else begin
                  r_count <= r_count + 4'd1;
               end
            end
            DONE: begin
               sramChipEnable_n   <= 1'b1;
               sramOutputEnable_n <= 1'b1;
               sramWriteEnable_n  <= 1'b1;
               sramDataDrive      <= 1'b0;
               r_state            <= IDLE;
            end
            default: begin
               sramChipEnable_n   <= 1'b1;
               sramOutputEnable_n <= 1'b1;
               sramWriteEnable_n  <= 1'b1;
               sramDataDrive      <= 1'b0;
               r_count            <= '0;
               r_state            <= IDLE;
            end
         endcase
      end
   end

`ifdef SRAM_ARB_STATS_EN
   logic        w_mcu_waiting;
   logic [15:0] r_stall_count;

   // IDLE counts as waiting too: the MCU has not been granted yet.
   assign w_mcu_waiting = (mcuWriteRequest || mcuReadRequest) &&
                          !((r_state != IDLE) && (r_requester != VIDEO));

   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         r_stall_count <= '0;
      end else if (w_mcu_waiting && (r_stall_count != 16'hFFFF)) begin
         r_stall_count <= r_stall_count + 16'd1;
      end
   end

   assign mcuStallCycles = r_stall_count;
`endif

endmodule
`default_nettype wire

// File: tb/tb_sram_arbiter.sv
`default_nettype none
// tb_sram_arbiter: directed self-checking bench for sram_arbiter, ACCESS_CYCLES=2.
// Revision: 1.0
module tb_sram_arbiter;

   localparam int c_AC = 2;

   logic        clock = 1'b0;
   logic        reset;
   logic        videoReadRequest;
   logic [16:0] videoAddress;
   logic [7:0]  videoReadData;
   logic        videoReadComplete;
   logic        mcuWriteRequest;
   logic        mcuReadRequest;
   logic [16:0] mcuAddress;
   logic [7:0]  mcuWriteData;
   logic        mcuWriteComplete;
   logic [7:0]  mcuReadData;
   logic        mcuReadComplete;
   logic [16:0] sramAddress;
   logic [7:0]  sramDataOut;
   logic [7:0]  sramDataIn;
   logic        sramDataDrive;
   logic        sramChipEnable_n;
   logic        sramOutputEnable_n;
   logic        sramWriteEnable_n;
`ifdef SRAM_ARB_STATS_EN
   logic [15:0] mcuStallCycles;
`endif

   int checks = 0;
   int errors = 0;
   int we_pulses = 0;
   int wr_done = 0;
   logic prev_we = 1'b1;

   always #5 clock = ~clock;

   sram_arbiter #(.ACCESS_CYCLES(c_AC)) dut (
      .clock              (clock),
      .reset              (reset),
      .videoReadRequest   (videoReadRequest),
      .videoAddress       (videoAddress),
      .videoReadData      (videoReadData),
      .videoReadComplete  (videoReadComplete),
      .mcuWriteRequest    (mcuWriteRequest),
      .mcuReadRequest     (mcuReadRequest),
      .mcuAddress         (mcuAddress),
      .mcuWriteData       (mcuWriteData),
      .mcuWriteComplete   (mcuWriteComplete),
      .mcuReadData        (mcuReadData),
      .mcuReadComplete    (mcuReadComplete),
      .sramAddress        (sramAddress),
      .sramDataOut        (sramDataOut),
      .sramDataIn         (sramDataIn),
      .sramDataDrive      (sramDataDrive),
      .sramChipEnable_n   (sramChipEnable_n),
      .sramOutputEnable_n (sramOutputEnable_n),
      .sramWriteEnable_n  (sramWriteEnable_n)
`ifdef SRAM_ARB_STATS_EN
      ,
      .mcuStallCycles     (mcuStallCycles)
`endif
   );

   // Count write-enable falling edges and write completions on the sampling edge.
   always @(negedge clock) begin
      if (!sramWriteEnable_n && prev_we) we_pulses++;
      prev_we = sramWriteEnable_n;
      if (mcuWriteComplete) wr_done++;
   end

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s got %h expected %h", tag, got, exp);
      end
   endtask

   task automatic tick();
      @(negedge clock);
      #1;
   endtask

   // Waits for the selected complete pulse (0 video, 1 write, 2 read).
   task automatic wait_done(input int which, output int lat);
      logic seen;
      seen = 1'b0;
      lat  = 0;
      for (int k = 0; k < 20 && !seen; k++) begin
         tick();
         lat++;
         case (which)
            0:       seen = videoReadComplete;
            1:       seen = mcuWriteComplete;
            default: seen = mcuReadComplete;
         endcase
      end
      if (!seen) check("wait_done_timeout", 32'd0, 32'd1);
   endtask

   // Runs n sampling cycles, dropping each request on its pulse; -2 marks a repeat pulse.
   task automatic run_order(input int n, output int iv, output int iw, output int ir);
      iv = -1; iw = -1; ir = -1;
      for (int k = 1; k <= n; k++) begin
         tick();
         if (videoReadComplete) begin iv = (iv < 0) ? k : -2; videoReadRequest = 1'b0; end
         if (mcuWriteComplete)  begin iw = (iw < 0) ? k : -2; mcuWriteRequest  = 1'b0; end
         if (mcuReadComplete)   begin ir = (ir < 0) ? k : -2; mcuReadRequest   = 1'b0; end
      end
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog expired");
      $fatal(1, "watchdog");
   end

   initial begin
      int lat, iv, iw, ir, snap_we, snap_wr, bad_lat;
      reset = 1'b1;
      videoReadRequest = 1'b0; mcuWriteRequest = 1'b0; mcuReadRequest = 1'b0;
      videoAddress = '0; mcuAddress = '0; mcuWriteData = '0; sramDataIn = '0;
      tick(); tick();
      check("rst_ce_n",  {31'd0, sramChipEnable_n},   32'd1);
      check("rst_oe_n",  {31'd0, sramOutputEnable_n}, 32'd1);
      check("rst_we_n",  {31'd0, sramWriteEnable_n},  32'd1);
      check("rst_drive", {31'd0, sramDataDrive},      32'd0);
      check("rst_addr",  {15'd0, sramAddress},        32'd0);
      check("rst_dout",  {24'd0, sramDataOut},        32'd0);
      check("rst_cmpl",  {29'd0, videoReadComplete, mcuWriteComplete, mcuReadComplete}, 32'd0);
      check("rst_rdata", {16'd0, videoReadData, mcuReadData}, 32'd0);
`ifdef SRAM_ARB_STATS_EN
      check("rst_stall", {16'd0, mcuStallCycles}, 32'd0);
`endif
      reset = 1'b0;
      tick();

      // Video read at 0x00123
      videoAddress = 17'h00123; sramDataIn = 8'hA5; videoReadRequest = 1'b1;
      tick();
      check("vr1_ce_oe", {30'd0, sramChipEnable_n, sramOutputEnable_n}, 32'd0);
      check("vr1_addr",  {15'd0, sramAddress}, 32'h00123);
      check("vr1_drive", {31'd0, sramDataDrive}, 32'd0);
      tick();
      check("vr2_oe",    {31'd0, sramOutputEnable_n}, 32'd0);
      check("vr2_cmpl",  {31'd0, videoReadComplete}, 32'd0);
      tick();
      check("vr3_cmpl",  {31'd0, videoReadComplete}, 32'd1);
      check("vr3_data",  {24'd0, videoReadData}, 32'hA5);
      check("vr3_ce_oe", {30'd0, sramChipEnable_n, sramOutputEnable_n}, 32'd1);
      videoReadRequest = 1'b0; sramDataIn = 8'h00;
      tick();
      check("vr4_cmpl",  {31'd0, videoReadComplete}, 32'd0);
      check("vr4_hold",  {24'd0, videoReadData}, 32'hA5);
      check("vr4_ce",    {31'd0, sramChipEnable_n}, 32'd1);

      // MCU write 0x3C to 0x1FFFF
      snap_we = we_pulses; snap_wr = wr_done;
      mcuAddress = 17'h1FFFF; mcuWriteData = 8'h3C; mcuWriteRequest = 1'b1;
      tick();
      check("wr1_pins",  {28'd0, sramChipEnable_n, sramOutputEnable_n, sramWriteEnable_n, sramDataDrive}, 32'b0111);
      check("wr1_addr",  {15'd0, sramAddress}, 32'h1FFFF);
      check("wr1_dout",  {24'd0, sramDataOut}, 32'h3C);
      tick();
      check("wr2_we",    {31'd0, sramWriteEnable_n}, 32'd0);
      tick();
      check("wr3_we",    {31'd0, sramWriteEnable_n}, 32'd0);
      check("wr3_cmpl",  {31'd0, mcuWriteComplete}, 32'd0);
      tick();
      check("wr4_pins",  {29'd0, sramChipEnable_n, sramWriteEnable_n, sramDataDrive}, 32'b011);
      check("wr4_cmpl",  {31'd0, mcuWriteComplete}, 32'd1);
      mcuWriteRequest = 1'b0;
      tick();
      check("wr5_idle",  {30'd0, sramChipEnable_n, sramDataDrive}, 32'b10);
      check("wr_pulses", we_pulses - snap_we, 32'd1);
      check("wr_cmpls",  wr_done - snap_wr, 32'd1);

      // All three requesters at once
      sramDataIn = 8'h5A; videoAddress = 17'h00040; mcuAddress = 17'h00801; mcuWriteData = 8'h11;
      videoReadRequest = 1'b1; mcuWriteRequest = 1'b1; mcuReadRequest = 1'b1;
      run_order(16, iv, iw, ir);
      check("all3_video", iv, 32'd3);
      check("all3_write", iw, 32'd8);
      check("all3_read",  ir, 32'd12);
      check("all3_rdata", {24'd0, mcuReadData}, 32'h5A);

      // Video arriving during an MCU read goes ahead of a pending MCU write
      mcuAddress = 17'h00022; sramDataIn = 8'hC3; mcuReadRequest = 1'b1;
      tick();
      videoReadRequest = 1'b1; mcuWriteRequest = 1'b1;
      run_order(16, iv, iw, ir);
      check("pri_read",  ir, 32'd2);
      check("pri_video", iv, 32'd6);
      check("pri_write", iw, 32'd11);

      // 100 random writes, request dropped on the complete pulse
      snap_we = we_pulses; snap_wr = wr_done; bad_lat = 0;
      for (int i = 0; i < 100; i++) begin
         mcuAddress = 17'($urandom); mcuWriteData = 8'($urandom); mcuWriteRequest = 1'b1;
         wait_done(1, lat);
         if (lat != c_AC + 2) bad_lat++;
         mcuWriteRequest = 1'b0;
         tick();
      end
      tick(); tick();
      check("rnd_pulses",  we_pulses - snap_we, 32'd100);
      check("rnd_cmpls",   wr_done - snap_wr, 32'd100);
      check("rnd_latency", bad_lat, 32'd0);

      // Reset in the middle of the write pulse
      mcuAddress = 17'h0AAAA; mcuWriteData = 8'h77; mcuWriteRequest = 1'b1;
      tick(); tick();
      check("rw_we_low", {31'd0, sramWriteEnable_n}, 32'd0);
      snap_wr = wr_done; snap_we = we_pulses;
      #2 reset = 1'b1;
      #1;
      check("rw_async",  {29'd0, sramWriteEnable_n, sramDataDrive, sramChipEnable_n}, 32'b101);
      check("rw_addr",   {15'd0, sramAddress}, 32'd0);
      tick(); tick();
      check("rw_nocmpl", wr_done - snap_wr, 32'd0);
      reset = 1'b0;
      wait_done(1, lat);
      check("rw_relat",  lat, c_AC + 2);
      check("rw_recmpl", wr_done - snap_wr, 32'd1);
      check("rw_repulse", we_pulses - snap_we, 32'd1);
      mcuWriteRequest = 1'b0;
      tick();

`ifdef SRAM_ARB_STATS_EN
      begin
         int s0;
         videoAddress = 17'h00005; videoReadRequest = 1'b1;
         tick();
         s0 = int'(mcuStallCycles);
         mcuReadRequest = 1'b1;
         run_order(12, iv, iw, ir);
         check("st_delta", int'(mcuStallCycles) - s0, 32'd4);
         force dut.r_stall_count = 16'hFFFF;
         tick();
         release dut.r_stall_count;
         videoReadRequest = 1'b1;
         tick();
         mcuReadRequest = 1'b1;
         run_order(12, iv, iw, ir);
         check("st_sat", {16'd0, mcuStallCycles}, 32'hFFFF);
      end
`endif

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
`default_nettype wire
